// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display scanner.
// Contents:
//   NIBBLE_W     width of one hex digit
//   MAX_DIGITS   largest supported digit count
//   digit_idx_t  digit index wide enough for MAX_DIGITS
//   idx_width()  index width for a given digit count (minimum 1)
//   digit_slice() nibble idx of a packed value
package hex_display_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;
  localparam int IDX_MAX_W  = 3;

  typedef logic [IDX_MAX_W-1:0] digit_idx_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NIBBLE_W-1:0] digit_slice(
    input logic [MAX_DIGITS*NIBBLE_W-1:0] value,
    input digit_idx_t                     idx
  );
    return value[idx*NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler for display scanning and debounce timing.
// Counts 0..PRESCALE-1 and wraps; TICK is high during the last count.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-high reset (count returns to 0)
//   TICK  high for one cycle every PRESCALE cycles
module scan_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int               CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  assign TICK = (count == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (TICK) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Scans one digit per prescaler slot, presents the active nibble for the
// downstream hex decoder and drives one-cold active-low digit enables.
// New values are taken through a LOAD/READY handshake and only become
// visible at a frame boundary, so a frame never mixes two values.
// Ports:
//   CLK     system clock
//   RST     asynchronous active-high reset
//   DATA    packed value, digit i = DATA[4i+3:4i], digit 0 rightmost
//   LOAD    capture request, honoured only while READY=1
//   READY   high when a new value can be captured
//   NIBBLE  nibble of the active digit
//   AN      active-low digit enables, one-cold
//   FRAME   one-cycle pulse on the last cycle of each full scan
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (never digit 0)
//                          are blanked by holding their AN bit high.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] DATA,
  input  logic                         LOAD,
  output logic                         READY,
  output logic [NIBBLE_W-1:0]          NIBBLE,
  output logic [NUM_DIGITS-1:0]        AN,
  output logic                         FRAME
);

  localparam int DATA_W = NUM_DIGITS * NIBBLE_W;
  localparam int IDX_W  = idx_width(NUM_DIGITS);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                               tick;
  logic                               frame_end;
  idx_t                               idx;
  logic [DATA_W-1:0]                  display;
  logic [DATA_W-1:0]                  pending;
  logic                               pend_flag;
  logic                               ready_q;
  logic [MAX_DIGITS*NIBBLE_W-1:0]     display_wide;
  logic [NUM_DIGITS-1:0]              an_n;

  scan_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .CLK (CLK),
    .RST (RST),
    .TICK(tick)
  );

  assign frame_end = tick && (idx == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx       <= '0;
      display   <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      if (tick) begin
        idx <= frame_end ? '0 : idx + IDX_W'(1);
      end
      // READY=1 implies no pending value, so a capture and a commit never
      // fire together; a capture in the frame-end cycle waits one frame.
      if (frame_end && pend_flag) begin
        display   <= pending;
        pend_flag <= 1'b0;
        ready_q   <= 1'b1;
      end
      if (LOAD && ready_q) begin
        pending   <= DATA;
        pend_flag <= 1'b1;
        ready_q   <= 1'b0;
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    display_wide             = '0;
    display_wide[DATA_W-1:0] = display;
  end

  assign NIBBLE = digit_slice(display_wide, digit_idx_t'(idx));
  assign READY  = ready_q;
  assign FRAME  = frame_end;

  always_comb begin
    an_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_n[i] = (idx != IDX_W'(i));
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero; the scan
  // runs from the top digit down and stops short of digit 0.
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (display[i*NIBBLE_W +: NIBBLE_W] == 4'h0);
      blank[i] = zero_run;
    end
  end

  assign AN = an_n | blank;
`else
  assign AN = an_n;
`endif

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Time-multiplexed driver for a multi-digit common-anode 7-segment display; sits directly upstream of hexdecoder. Holds a packed hex value, cycles one digit per prescaler slot, presents the active digit's nibble on NIBBLE (wired to hexdecoder INP) and drives the active-low digit enables. New values are accepted through a LOAD/READY handshake and applied only on frame boundaries, so a frame never shows a torn value.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 1..8.
PRESCALE, 50000, CLK cycles per digit slot; legal minimum 2.

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
DATA  input  4*NUM_DIGITS  packed value; digit i = DATA[4i+3:4i], digit 0 is rightmost
LOAD  input  1  request to capture DATA; honoured only when READY=1
READY  output  1  high when a new value can be captured
NIBBLE  output  4  nibble of the active digit, to hexdecoder INP
AN  output  NUM_DIGITS  digit enables, active-low, one-cold
FRAME  output  1  one-cycle pulse on the last cycle of each full scan

Behaviour:
- Clocking: single clock CLK. RST is asynchronous and active-high. All state resets immediately on RST.
- Reset values: prescaler=0, digit index=0, display register=0, pending register=0, pending flag=0, READY=1, FRAME=0, NIBBLE=4'h0, AN=all ones except bit0=0.
- Prescaler: counts 0..PRESCALE-1 and then wraps. tick = (count==PRESCALE-1).
- Digit index: advances by 1 on tick. It wraps from NUM_DIGITS-1 to 0.
- Frame end: a tick while digit index == NUM_DIGITS-1. FRAME is asserted for exactly that cycle.
- Outputs: NIBBLE and AN are decoded from registered state only, with no combinational path from any input.
  - They change in the cycle after the tick, together with the digit index.
  - AN bit i = 0 iff index==i.
  - NIBBLE = display register slice for the index.
- Handshake:
  - LOAD && READY at a rising edge: pending <= DATA, pending flag <= 1, READY <= 0.
  - LOAD while READY=0 is ignored. There is no queueing and no error flag.
- Frame-end commit: if the pending flag is set, display <= pending, pending flag <= 0, READY <= 1. Both take effect at the same edge, so the first digit of the next frame shows the new value.
- Simultaneous LOAD and frame end with READY=1: the capture wins. The commit sees the old flag (0), so the new value is committed at the following frame end. Latency from accept to display is therefore 1 to 2 frames.
- Worst-case READY low time: NUM_DIGITS*PRESCALE cycles.
- RST mid-frame or mid-handshake: any pending value is discarded. The display returns to 0 and digit 0.
- NUM_DIGITS=1: every tick is a frame end, and AN is constantly 0.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit i>0 is blanked (its AN bit forced to 1, NIBBLE still driven) when it and every digit above it in the display register are 0. Digit 0 is never blanked.
- Undefined: all digits are always shown. Behaviour is as specified above.
- The blank mask is computed from the display register only. It therefore updates only on frame-end commits.

Decomposition:
- Shared package hex_display_pkg holds:
  - localparam NIBBLE_W=4
  - function digit_slice(value, idx)
  - typedef for the digit index width, clog2(NUM_DIGITS), minimum 1
- One natural sub-module, scan_prescaler: parameter PRESCALE; ports CLK, RST and tick output. It is reused by other display and debounce logic.
- Handshake, registers and decode stay in the top module.

Test Plan:
- Reset: assert RST mid-count. Required: AN=4'b1110, NIBBLE=0, READY=1 and FRAME=0 immediately, asynchronously; after release the first tick comes PRESCALE cycles later.
- Scan (PRESCALE=4, NUM_DIGITS=4, display 16'h1234): AN steps 1110→1101→1011→0111 every 4 cycles, NIBBLE steps 4,3,2,1. FRAME pulses once every 16 cycles.
- Handshake: LOAD with DATA=16'hBEEF mid-frame. Required: READY drops the next cycle; a second LOAD of 16'h0000 while READY=0 is ignored; AN=1110 shows NIBBLE=F in the first slot after FRAME, and READY returns to 1 then.
- Collision: LOAD=1, READY=1 in the FRAME cycle with DATA=16'hA5A5. Required: the old value is still shown for the whole next frame, and A5A5 appears after the second FRAME.
- Reset mid-handshake: accept 16'h9999, then assert RST before frame end. Required: display stays 0 after reset and READY=1.
- LOAD 16'h0040 with LEADING_ZERO_BLANK_EN defined. Required: AN digits 3 and 2 are never low, digits 1 and 0 scan normally. Without the macro, all four digits scan.
